two_digit_up_timer: RTL and testbench

TWO_DIGIT_UP_TIMER -- requirements
Module: two_digit_up_timer

---
 rtl/two_digit_up_timer_pkg.sv | 20 ++
 rtl/two_digit_up_timer_up_digit_counter.sv | 49 ++++
 rtl/two_digit_up_timer.sv | 133 +++++++++++++
 tb/tb_two_digit_up_timer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/two_digit_up_timer_pkg.sv
// ---------------------------------------------------------------------------
// two_digit_up_timer_pkg
// Constants shared by the two-digit BCD timers. This package holds the
// controller state encoding and the largest legal BCD digit value.
// Ports: none (package only).
// ---------------------------------------------------------------------------
package two_digit_up_timer_pkg;

  // Controller states. IDLE means digits 00 with the prescaler at 0, RUN means
  // counting, and FULL means saturated at 99 (non-rollover build only).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } timer_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

endpackage

// File: rtl/two_digit_up_timer_up_digit_counter.sv
// ---------------------------------------------------------------------------
// up_digit_counter
// One BCD digit that counts upward. Digits are chained by connecting the
// carry-out of one digit to the increment input of the next.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-low reset (digit -> 0)
//   i_clear  - synchronous clear to 0, has priority over i_inc
//   i_inc    - advance the digit by one on this edge
//   i_wrap   - 1: 9 wraps to 0 on increment; 0: 9 holds (saturate)
//   o_digit  - registered BCD digit, always 0..9
//   o_carry  - increment arriving while the digit sits at 9 (same cycle)
// ---------------------------------------------------------------------------
module up_digit_counter
  import two_digit_up_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_inc,
  input  logic       i_wrap,
  output logic [3:0] o_digit,
  output logic       o_carry
);

  logic [3:0] r_digit;
  logic       w_at_max;

  // ">=" instead of "==" folds any out-of-range code back to a legal digit
  // on the next increment instead of letting it run through A-F.
  assign w_at_max = (r_digit >= BCD_MAX);
  assign o_carry  = i_inc && w_at_max;
  assign o_digit  = r_digit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digit <= BCD_MIN;
    end else if (i_clear) begin
      r_digit <= BCD_MIN;
    end else if (i_inc) begin
      if (w_at_max) begin
        r_digit <= i_wrap ? BCD_MIN : BCD_MAX;
      end else begin
        r_digit <= r_digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/two_digit_up_timer.sv
// ---------------------------------------------------------------------------
// two_digit_up_timer
// Elapsed-seconds counter that runs 00..99 in BCD. A prescaler divides clk
// into one-cycle second ticks. Each tick advances the ones digit, and the ones
// carry advances the tens digit on the same edge.
// Build option: TIMER_ROLLOVER_EN
//   defined   - a tick at 99 wraps to 00 and TwoDigitMax pulses for one cycle
//   undefined - the counter saturates at 99 in FULL and TwoDigitMax stays high
//               until Timer_Clear or reset
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-low reset
//   Timer_Clear  - synchronous return to 00 / IDLE, highest priority
//   Timer_Enable - level enable; counting advances only while high
//   Tens_Digit   - registered BCD tens digit
//   Ones_Digit   - registered BCD ones digit
//   TwoDigitMax  - registered end-of-range flag (behaviour per build option)
// ---------------------------------------------------------------------------
module two_digit_up_timer
  import two_digit_up_timer_pkg::*;
#(
  parameter int CLKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Timer_Clear,
  input  logic       Timer_Enable,
  output logic [3:0] Tens_Digit,
  output logic [3:0] Ones_Digit,
  output logic       TwoDigitMax
);

  localparam int             PW        = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLKS_PER_SEC - 1);

`ifdef TIMER_ROLLOVER_EN
  localparam logic TENS_WRAP = 1'b1;
`else
  localparam logic TENS_WRAP = 1'b0;
`endif

  timer_state_t  r_state;
  timer_state_t  w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          r_max;
  logic          w_count_en;
  logic          w_tick;
  logic          w_ones_carry;
  logic          w_tens_carry;
  logic          w_reach_99;

  // The prescaler also runs in IDLE when enabled. The IDLE->RUN transition
  // happens on that same first edge, so the first second lasts exactly
  // CLKS_PER_SEC enabled cycles.
  assign w_count_en = Timer_Enable && (r_state != ST_FULL);
  assign w_tick     = w_count_en && (r_presc == PRESC_MAX);

  // A tick taken at 98 makes this edge the one on which the digits reach 99.
  assign w_reach_99 = w_tick && (Tens_Digit == BCD_MAX) && (Ones_Digit == (BCD_MAX - 4'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (Timer_Clear) begin
      r_presc <= '0;
    end else if (w_count_en) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  up_digit_counter u_ones (
    .clk     (clk),
    .rst     (rst),
    .i_clear (Timer_Clear),
    .i_inc   (w_tick),
    .i_wrap  (1'b1),
    .o_digit (Ones_Digit),
    .o_carry (w_ones_carry)
  );

  up_digit_counter u_tens (
    .clk     (clk),
    .rst     (rst),
    .i_clear (Timer_Clear),
    .i_inc   (w_ones_carry),
    .i_wrap  (TENS_WRAP),
    .o_digit (Tens_Digit),
    .o_carry (w_tens_carry)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (Timer_Enable) w_state_nxt = ST_RUN;
`ifdef TIMER_ROLLOVER_EN
      ST_RUN:  w_state_nxt = ST_RUN;
`else
      // The tens carry only fires on a tick at 99, and FULL blocks ticks, so
      // it acts only as a backstop against a tick slipping past saturation.
      ST_RUN:  if (w_reach_99 || w_tens_carry) w_state_nxt = ST_FULL;
`endif
      ST_FULL: w_state_nxt = ST_FULL;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (Timer_Clear) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_max <= 1'b0;
    end else if (Timer_Clear) begin
      r_max <= 1'b0;
    end else begin
`ifdef TIMER_ROLLOVER_EN
      // The wrap 99->00 is the tens carry; it registers as a one-cycle pulse.
      r_max <= w_tens_carry;
`else
      r_max <= (w_state_nxt == ST_FULL);
`endif
    end
  end

  assign TwoDigitMax = r_max;

endmodule

// File: tb/tb_two_digit_up_timer.sv
// ---------------------------------------------------------------------------
// tb_two_digit_up_timer
// Scoreboard bench for two_digit_up_timer with CLKS_PER_SEC = 4. A small
// seconds/prescaler model predicts each edge, and the bench queues the
// prediction when it drives the inputs and compares it after the edge.
// ---------------------------------------------------------------------------
module tb_two_digit_up_timer;

  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       Timer_Clear;
  logic       Timer_Enable;
  logic [3:0] Tens_Digit;
  logic [3:0] Ones_Digit;
  logic       TwoDigitMax;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: seconds count 0..99, prescaler, saturation and max flag.
  int m_cnt = 0;
  int m_pre = 0;
  bit m_full = 1'b0;
  bit m_max  = 1'b0;

  logic [8:0] sb_q[$];

  two_digit_up_timer #(.CLKS_PER_SEC(CPS)) dut (
    .clk          (clk),
    .rst          (rst),
    .Timer_Clear  (Timer_Clear),
    .Timer_Enable (Timer_Enable),
    .Tens_Digit   (Tens_Digit),
    .Ones_Digit   (Ones_Digit),
    .TwoDigitMax  (TwoDigitMax)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_pre  = 0;
    m_full = 1'b0;
    m_max  = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit clr);
    bit wrapped;
    wrapped = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (en && !m_full) begin
        if (m_pre == CPS - 1) begin
          m_pre = 0;
          if (m_cnt == 99) begin
`ifdef TIMER_ROLLOVER_EN
            m_cnt   = 0;
            wrapped = 1'b1;
`endif
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
`ifdef TIMER_ROLLOVER_EN
      m_max = wrapped;
`else
      if (m_cnt == 99) begin
        m_full = 1'b1;
        m_max  = 1'b1;
      end
`endif
    end
  endtask

  function automatic logic [8:0] model_out();
    return {4'(m_cnt / 10), 4'(m_cnt % 10), m_max};
  endfunction

  // Drive one cycle of stimulus, queue the prediction, compare after the edge.
  task automatic step(input bit en, input bit clr);
    logic [8:0] exp;
    Timer_Enable = en;
    Timer_Clear  = clr;
    model_edge(en, clr);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check("cycle", {Tens_Digit, Ones_Digit, TwoDigitMax}, exp);
    check("bcd", {31'd0, (Tens_Digit <= 4'd9) && (Ones_Digit <= 4'd9)}, 32'd1);
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 1'b0);
  endtask

  initial begin
    rst          = 1'b0;
    Timer_Clear  = 1'b0;
    Timer_Enable = 1'b0;
    #12;
    check("reset_state", {Tens_Digit, Ones_Digit, TwoDigitMax}, 9'd0);
    @(negedge clk);
    rst = 1'b1;

    // Forty enabled cycles from reset give ten seconds.
    run(40, 1'b1);
    check("cyc40_digits", {Tens_Digit, Ones_Digit}, 8'h10);
    check("cyc40_max", TwoDigitMax, 1'b0);

    // Pause with the prescaler at 2. Two enabled cycles after resume finish the second.
    run(2, 1'b1);
    run(10, 1'b0);
    check("pause_frozen", {Tens_Digit, Ones_Digit}, 8'h10);
    run(1, 1'b1);
    check("resume_1", {Tens_Digit, Ones_Digit}, 8'h10);
    run(1, 1'b1);
    check("resume_2", {Tens_Digit, Ones_Digit}, 8'h11);

    // Clear during a tick cycle at 37.
    step(1'b0, 1'b1);
    run(37 * CPS + CPS - 1, 1'b1);
    check("at_37", {Tens_Digit, Ones_Digit}, 8'h37);
    step(1'b1, 1'b1);
    check("clear_in_tick", {Tens_Digit, Ones_Digit, TwoDigitMax}, 9'd0);
    run(CPS, 1'b1);
    check("after_clear", {Tens_Digit, Ones_Digit}, 8'h01);

    // Full range up to 99 and the end-of-range behaviour.
    step(1'b0, 1'b1);
    run(396, 1'b1);
    check("at_396", {Tens_Digit, Ones_Digit}, 8'h99);
`ifdef TIMER_ROLLOVER_EN
    check("at_396_max", TwoDigitMax, 1'b0);
    run(4, 1'b1);
    check("at_400", {Tens_Digit, Ones_Digit, TwoDigitMax}, {8'h00, 1'b1});
    run(1, 1'b1);
    check("at_401_max", TwoDigitMax, 1'b0);
    run(3, 1'b1);
    check("at_404", {Tens_Digit, Ones_Digit}, 8'h01);
`else
    check("at_396_max", TwoDigitMax, 1'b1);
    run(8, 1'b1);
    check("full_hold", {Tens_Digit, Ones_Digit, TwoDigitMax}, {8'h99, 1'b1});
`endif

    // Asynchronous reset mid-second at 55.
    step(1'b0, 1'b1);
    run(55 * CPS + 2, 1'b1);
    check("at_55", {Tens_Digit, Ones_Digit}, 8'h55);
    rst = 1'b0;
    #1;
    check("async_reset", {Tens_Digit, Ones_Digit, TwoDigitMax}, 9'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run(CPS - 1, 1'b1);
    check("post_rst_3", {Tens_Digit, Ones_Digit}, 8'h00);
    run(1, 1'b1);
    check("post_rst_4", {Tens_Digit, Ones_Digit}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
